// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA read arbiter.
package dma_arb_pkg;

  localparam int NUM_REQ_MAX = 8;
  localparam int ADDR_W      = 64;
  localparam int LEN_W       = 32;
  localparam int DATA_W      = 512;
  localparam int STAT_WORDS  = 16;

  typedef logic [2:0] req_id_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  // status word indices
  localparam int STAT_OUTSTANDING = 0;
  localparam int STAT_FLAGS       = 1;
  localparam int STAT_GRANT_BASE  = 2;
  localparam int STAT_BEATS       = 10;

  // bits within STAT_FLAGS
  localparam int FLAG_LEN_ZERO   = 0;
  localparam int FLAG_DATA_EMPTY = 1;

endpackage

// File: rtl/dma_arb_tag_fifo.sv
// Requester-id FIFO: one entry per issued DMA read, popped on the last data beat.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module dma_arb_tag_fifo
  import dma_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  req_id_t                  push_id,
  input  logic                     pop,
  output req_id_t                  head_id,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  req_id_t       mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rptr];

  // pointers and occupancy; push and pop together leave count unchanged
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: entries are only read once counted valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_id;
  end

endmodule

// File: rtl/dma_read_arbiter.sv
// Round-robin arbiter sharing one DMA read channel among NUM_REQ requesters.
// Returned data is routed back by a tag FIFO of requester ids.
// Optional per-requester grant and beat counters: define DMA_RD_ARB_STATS_EN.
module dma_read_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  // per-requester read commands
  input  logic [NUM_REQ-1:0]             s_axis_req_cmd_valid,
  output logic [NUM_REQ-1:0]             s_axis_req_cmd_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] s_axis_req_cmd_addr,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]  s_axis_req_cmd_len,
  // shared DMA read command
  output logic                           m_axis_dma_read_cmd_valid,
  input  logic                           m_axis_dma_read_cmd_ready,
  output logic [ADDR_W-1:0]              m_axis_dma_read_cmd_addr,
  output logic [LEN_W-1:0]               m_axis_dma_read_cmd_len,
  // shared DMA read data
  input  logic                           s_axis_dma_read_data_valid,
  output logic                           s_axis_dma_read_data_ready,
  input  logic [DATA_W-1:0]              s_axis_dma_read_data_data,
  input  logic                           s_axis_dma_read_data_last,
  // per-requester read data (data/last broadcast)
  output logic [NUM_REQ-1:0]             m_axis_req_data_valid,
  input  logic [NUM_REQ-1:0]             m_axis_req_data_ready,
  output logic [DATA_W-1:0]              m_axis_req_data_data,
  output logic                           m_axis_req_data_last,
  output logic [STAT_WORDS-1:0][31:0]    status_reg
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e        state, state_nxt;
  req_id_t           last_grant, grant_id, head_id;
  logic              grant_hit, len_zero, push, pop, len0_hit;
  logic              fifo_full, fifo_empty, beat;
  logic              flag_len0, flag_empty;
  logic [CNT_W-1:0]  fifo_count;

  // round-robin search from last_grant+1; walking offsets downward lets the
  // nearest valid requester win
  always_comb begin
    int idx;
    idx       = 0;
    grant_hit = 1'b0;
    grant_id  = last_grant;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (s_axis_req_cmd_valid[idx]) begin
        grant_hit = 1'b1;
        grant_id  = req_id_t'(idx);
      end
    end
  end

  assign len_zero = (s_axis_req_cmd_len[grant_id] == '0);

  // next state and grant; zero-length commands are swallowed without a tag,
  // so they do not wait on FIFO space
  always_comb begin
    state_nxt            = state;
    s_axis_req_cmd_ready = '0;
    push                 = 1'b0;
    len0_hit             = 1'b0;
    case (state)
      IDLE: begin
        if (rstn && grant_hit) begin
          if (len_zero) begin
            s_axis_req_cmd_ready[grant_id] = 1'b1;
            len0_hit                       = 1'b1;
          end else if (!fifo_full) begin
            s_axis_req_cmd_ready[grant_id] = 1'b1;
            push                           = 1'b1;
            state_nxt                      = ISSUE;
          end
        end
      end
      ISSUE: if (m_axis_dma_read_cmd_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state, grant pointer and held command
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                    <= IDLE;
      last_grant               <= req_id_t'(NUM_REQ - 1);
      m_axis_dma_read_cmd_addr <= '0;
      m_axis_dma_read_cmd_len  <= '0;
    end else begin
      state <= state_nxt;
      if (|s_axis_req_cmd_ready) last_grant <= grant_id;
      if (push) begin
        m_axis_dma_read_cmd_addr <= s_axis_req_cmd_addr[grant_id];
        m_axis_dma_read_cmd_len  <= s_axis_req_cmd_len[grant_id];
      end
    end
  end

  assign m_axis_dma_read_cmd_valid = (state == ISSUE);

  dma_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .push_id (grant_id),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // data steering follows the FIFO head; nothing is accepted with no tag
  always_comb begin
    m_axis_req_data_valid = '0;
    if (s_axis_dma_read_data_valid && !fifo_empty) m_axis_req_data_valid[head_id] = 1'b1;
  end

  assign s_axis_dma_read_data_ready = ~fifo_empty & m_axis_req_data_ready[head_id];
  assign m_axis_req_data_data       = s_axis_dma_read_data_data;
  assign m_axis_req_data_last       = s_axis_dma_read_data_last;
  assign beat                       = s_axis_dma_read_data_valid & s_axis_dma_read_data_ready;
  assign pop                        = beat & s_axis_dma_read_data_last;

  // sticky error flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flag_len0  <= 1'b0;
      flag_empty <= 1'b0;
    end else begin
      flag_len0  <= flag_len0 | len0_hit;
      flag_empty <= flag_empty | (s_axis_dma_read_data_valid & fifo_empty);
    end
  end

`ifdef DMA_RD_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt;
  logic [31:0]              beat_cnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
    // issued commands per requester
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                     grant_cnt[g] <= '0;
      else if (push && grant_id == req_id_t'(g))     grant_cnt[g] <= grant_cnt[g] + 32'd1;
    end
  end

  // forwarded data beats
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     beat_cnt <= '0;
    else if (beat) beat_cnt <= beat_cnt + 32'd1;
  end
`endif

  // status word assembly
  always_comb begin
    status_reg                                  = '0;
    status_reg[STAT_OUTSTANDING]                = 32'(fifo_count);
    status_reg[STAT_FLAGS][FLAG_LEN_ZERO]       = flag_len0;
    status_reg[STAT_FLAGS][FLAG_DATA_EMPTY]     = flag_empty;
`ifdef DMA_RD_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) status_reg[STAT_GRANT_BASE+i] = grant_cnt[i];
    status_reg[STAT_BEATS] = beat_cnt;
`endif
  end

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Scoreboard bench for dma_read_arbiter: stimulus pushes expected grants,
// commands and data beats; a negedge monitor pops and compares.
module tb_dma_read_arbiter;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [3:0]           rq_valid, rq_ready;
  logic [3:0][63:0]     rq_addr;
  logic [3:0][31:0]     rq_len;
  logic                 dc_valid, dc_ready;
  logic [63:0]          dc_addr;
  logic [31:0]          dc_len;
  logic                 dd_valid, dd_ready, dd_last;
  logic [511:0]         dd_data;
  logic [3:0]           rd_valid, rd_ready;
  logic [511:0]         rd_data;
  logic                 rd_last;
  logic [15:0][31:0]    status;

  typedef struct { int id; logic [511:0] d; logic l; } beat_t;

  int           total = 0, bad = 0, cyc = 0, grants = 0;
  int           exp_grant[$];
  logic [95:0]  exp_cmd[$];
  beat_t        exp_data[$];
  int           cmd_t[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dma_read_arbiter #(.NUM_REQ(4), .MAX_OUTSTANDING(16)) dut (
    .clk                        (clk),
    .rstn                       (rstn),
    .s_axis_req_cmd_valid       (rq_valid),
    .s_axis_req_cmd_ready       (rq_ready),
    .s_axis_req_cmd_addr        (rq_addr),
    .s_axis_req_cmd_len         (rq_len),
    .m_axis_dma_read_cmd_valid  (dc_valid),
    .m_axis_dma_read_cmd_ready  (dc_ready),
    .m_axis_dma_read_cmd_addr   (dc_addr),
    .m_axis_dma_read_cmd_len    (dc_len),
    .s_axis_dma_read_data_valid (dd_valid),
    .s_axis_dma_read_data_ready (dd_ready),
    .s_axis_dma_read_data_data  (dd_data),
    .s_axis_dma_read_data_last  (dd_last),
    .m_axis_req_data_valid      (rd_valid),
    .m_axis_req_data_ready      (rd_ready),
    .m_axis_req_data_data       (rd_data),
    .m_axis_req_data_last       (rd_last),
    .status_reg                 (status)
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm, input logic [511:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h with nothing expected", nm, act);
  endtask

  function automatic logic [511:0] mk(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ k;
    return {16{w}};
  endfunction

  // monitor: every handshake the DUT presents is matched against the scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (rq_ready != '0) begin
        grants++;
        if (exp_grant.size() == 0) unexp("grant", rq_ready);
        else begin
          int g;
          g = exp_grant.pop_front();
          chk("grant_id", rq_ready, 4'b0001 << g);
        end
      end
      if (dc_valid && dc_ready) begin
        cmd_t.push_back(cyc);
        if (exp_cmd.size() == 0) unexp("dma_cmd", {dc_addr, dc_len});
        else chk("dma_cmd", {dc_addr, dc_len}, exp_cmd.pop_front());
      end
      for (int i = 0; i < 4; i++) begin
        if (rd_valid[i] && rd_ready[i]) begin
          if (exp_data.size() == 0) unexp("data_beat", rd_data);
          else begin
            beat_t e;
            e = exp_data.pop_front();
            chk("data_id", i, e.id);
            chk("data", rd_data, e.d);
            chk("data_last", rd_last, e.l);
          end
        end
      end
    end
  end

  // called at posedge+1; holds a command until its ready pulse is seen
  task automatic issue_cmd(input int id, input logic [63:0] a, input logic [31:0] l);
    logic got;
    got = 1'b0;
    exp_grant.push_back(id);
    if (l != 0) exp_cmd.push_back({a, l});
    rq_valid[id] = 1'b1;
    rq_addr[id]  = a;
    rq_len[id]   = l;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = rq_ready[id];
    end
    if (!got) begin total++; bad++; $display("FAIL grant_wait: req%0d never granted", id); end
    @(posedge clk);
    #1 rq_valid[id] = 1'b0;
  endtask

  // called at posedge+1; holds one beat until accepted
  task automatic send_beat(input logic [511:0] d, input logic l);
    logic got;
    got      = 1'b0;
    dd_valid = 1'b1;
    dd_data  = d;
    dd_last  = l;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = dd_ready;
    end
    if (!got) begin total++; bad++; $display("FAIL beat_wait: beat never accepted"); end
    @(posedge clk);
    #1 dd_valid = 1'b0;
    dd_last = 1'b0;
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    rq_valid = '0;
    dd_valid = 1'b0;
    dd_last  = 1'b0;
    exp_grant.delete();
    exp_cmd.delete();
    exp_data.delete();
    cmd_t.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; rq_valid = '0; rq_addr = '0; rq_len = '0;
    dc_ready = 1'b0; dd_valid = 1'b0; dd_data = '0; dd_last = 1'b0; rd_ready = '0;
    rq_valid = 4'b0101;
    repeat (3) @(posedge clk);
    #1;
    // reset state: cmd ready suppressed even with valid requests
    chk("rst_cmd_ready", rq_ready, 4'b0000);
    chk("rst_dma_valid", dc_valid, 1'b0);
    chk("rst_data_ready", dd_ready, 1'b0);
    chk("rst_outstanding", status[0], 32'd0);
    chk("rst_flags", status[1], 32'd0);
    rq_valid = '0;
    rstn = 1'b1;

    // round robin: all four valid, expect 0,1,2,3,0 one issue per two cycles
    dc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rq_addr[i] = 64'h10000 * (i + 1);
      rq_len[i]  = 32'd4096;
    end
    foreach (exp_grant[k]) ; // queue empty here
    for (int k = 0; k < 5; k++) begin
      exp_grant.push_back(k % 4);
      exp_cmd.push_back({64'h10000 * ((k % 4) + 1), 32'd4096});
    end
    rq_valid = 4'hF;
    for (int n = 0; n < 60 && grants < 5; n++) @(posedge clk);
    #1 rq_valid = '0;
    dc_ready = 1'b0;
    @(negedge clk);
    chk("rr_hold_valid", dc_valid, 1'b1);
    chk("rr_outstanding", status[0], 32'd5);
    chk("rr_issue_count", cmd_t.size(), 4);
    if (cmd_t.size() >= 4)
      for (int k = 1; k < 4; k++) chk("rr_spacing", cmd_t[k] - cmd_t[k-1], 2);
`ifdef DMA_RD_ARB_STATS_EN
    chk("rr_grants0", status[2], 32'd2);
    chk("rr_grants1", status[3], 32'd1);
    chk("rr_grants3", status[5], 32'd1);
`else
    chk("rr_stats_off", status[2], 32'd0);
`endif
    // reset while ISSUE with 5 outstanding
    #1 rstn = 1'b0;
    #1;
    chk("rst_issue_valid", dc_valid, 1'b0);
    chk("rst_issue_outstanding", status[0], 32'd0);
    chk("rst_issue_grants", status[2], 32'd0);
    exp_grant.delete(); exp_cmd.delete(); cmd_t.delete();
    @(posedge clk);
    #1 rstn = 1'b1;

    // single command on req1, two beats routed back to it
    dc_ready = 1'b1;
    rd_ready = 4'hF;
    issue_cmd(1, 64'h1000, 32'd128);
    @(negedge clk);
    chk("r1_outstanding", status[0], 32'd1);
    @(posedge clk);
    #1;
    exp_data.push_back('{1, mk(1), 1'b0});
    exp_data.push_back('{1, mk(2), 1'b1});
    send_beat(mk(1), 1'b0);
    send_beat(mk(2), 1'b1);
    @(negedge clk);
    chk("r1_drained", status[0], 32'd0);
`ifdef DMA_RD_ARB_STATS_EN
    chk("r1_beats", status[10], 32'd2);
    chk("r1_grants1", status[3], 32'd1);
`else
    chk("r1_stats_off", status[10], 32'd0);
`endif
    do_reset();

    // fill 16 tags, 17th stalls until one tag retires
    dc_ready = 1'b1;
    for (int i = 0; i < 16; i++) issue_cmd(0, 64'h2000 + 64'(i) * 64'h40, 32'd64);
    exp_grant.push_back(2);
    exp_cmd.push_back({64'h9000, 32'd32});
    rq_valid[2] = 1'b1; rq_addr[2] = 64'h9000; rq_len[2] = 32'd32;
    repeat (3) begin
      @(negedge clk);
      chk("full_stall", rq_ready, 4'b0000);
    end
    chk("full_count", status[0], 32'd16);
    @(posedge clk);
    #1;
    exp_data.push_back('{0, mk(3), 1'b1});
    send_beat(mk(3), 1'b1);
    @(negedge clk);
    chk("full_regrant", rq_ready, 4'b0100);
    @(posedge clk);
    #1 rq_valid[2] = 1'b0;
    @(negedge clk);
    chk("full_refill", status[0], 32'd16);
    do_reset();

    // head requester back-pressures; no beat lost or reordered
    dc_ready = 1'b1;
    rd_ready = 4'b1011;
    issue_cmd(2, 64'hA000, 32'd128);
    issue_cmd(1, 64'hB000, 32'd64);
    exp_data.push_back('{2, mk(4), 1'b0});
    exp_data.push_back('{2, mk(5), 1'b1});
    exp_data.push_back('{1, mk(6), 1'b1});
    dd_valid = 1'b1; dd_data = mk(4); dd_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_data_ready", dd_ready, 1'b0);
      chk("bp_head_valid", rd_valid, 4'b0100);
    end
    @(posedge clk);
    #1 rd_ready = 4'hF;
    send_beat(mk(4), 1'b0);
    send_beat(mk(5), 1'b1);
    send_beat(mk(6), 1'b1);
    @(negedge clk);
    chk("bp_drained", status[0], 32'd0);

    // zero length command and data with no tag
    do_reset();
    dc_ready = 1'b1;
    issue_cmd(3, 64'hC000, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("len0_no_cmd", dc_valid, 1'b0);
    end
    chk("len0_flag", status[1], 32'd1);
    chk("len0_no_tag", status[0], 32'd0);
    @(posedge clk);
    #1 dd_valid = 1'b1; dd_data = mk(7); dd_last = 1'b1;
    @(negedge clk);
    chk("notag_ready", dd_ready, 1'b0);
    chk("notag_valid", rd_valid, 4'b0000);
    @(posedge clk);
    #1 dd_valid = 1'b0; dd_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("sticky_flags", status[1], 32'd3);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk("flags_cleared", status[1], 32'd0);

    chk("left_grants", exp_grant.size(), 0);
    chk("left_cmds", exp_cmd.size(), 0);
    chk("left_beats", exp_data.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/dma_read_arbiter.md
DMA_READ_ARBITER -- requirements
Module: dma_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16, meaning tag FIFO depth (power of 2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_axis_req_cmd[NUM_REQ]  axis_mem_cmd.slave  64b address / 32b length  per-requester read commands.
REQ-006 SHALL have port m_axis_dma_read_cmd  axis_mem_cmd.master  64b address / 32b length  shared DMA read command.
REQ-007 SHALL have port s_axis_dma_read_data  axi_stream.slave  512b data + last  shared DMA read data.
REQ-008 SHALL have port m_axis_req_data[NUM_REQ]  axi_stream.master  512b data + last  per-requester read data.
REQ-009 SHALL have port status_reg  output  16x32  counters/flags.

Function
REQ-010 Arbiter FSM SHALL have states IDLE (no cmd held) and ISSUE (cmd held on m_axis_dma_read_cmd).
REQ-011 IDLE -> ISSUE SHALL occur when any s_axis_req_cmd valid, tag FIFO not full, length != 0; grant is round-robin, search starting at (last_grant+1) mod NUM_REQ.
REQ-012 On grant, s_axis_req_cmd[g].ready SHALL pulse 1 cycle; address/length registered; requester id g pushed to tag FIFO same cycle.
REQ-013 In ISSUE m_axis_dma_read_cmd.valid SHALL be 1 with address/length stable until ready; on valid&ready -> IDLE; issue latency 1 cycle after grant minimum.
REQ-014 FIFO-full check SHALL use current-cycle occupancy; a concurrent pop does not enable a grant that cycle.
REQ-015 Command with length 0 SHALL be accepted (ready pulse), not issued, not pushed, and set sticky status_reg[1][0].
REQ-016 Data routing SHALL be combinational from tag FIFO head h: m_axis_req_data[h].valid = s.valid & ~empty; s_axis_dma_read_data.ready = m_axis_req_data[h].ready & ~empty; data/last broadcast to all, valid 0 to non-head.
REQ-017 Tag FIFO SHALL pop on s valid&ready&last; data beats beyond last belong to next head.
REQ-018 Data valid while FIFO empty SHALL be held off (ready 0) and set sticky status_reg[1][1].
REQ-019 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-020 status_reg[0] SHALL equal outstanding count (FIFO occupancy, 0..MAX_OUTSTANDING); unused words 0.
REQ-021 Sticky flags SHALL clear only on reset.

Reset
REQ-022 rstn low SHALL asynchronously force FSM IDLE, last_grant NUM_REQ-1 (first grant to 0), FIFO empty, all ready/valid outputs 0, status_reg 0.
REQ-023 Reset mid-command or mid-burst SHALL discard outstanding tags; no recovery of in-flight data.

Configuration
REQ-024 With DMA_RD_ARB_STATS_EN defined, status_reg[2+i] SHALL count grants to requester i and status_reg[10] total data beats forwarded, 32b wrapping.
REQ-025 Without DMA_RD_ARB_STATS_EN those words SHALL read 0 and the counters SHALL not be synthesised.

Structure
REQ-026 Package dma_arb_pkg SHALL hold NUM_REQ_MAX=8, req_id_t (3b), FSM state enum, status word index constants.
REQ-027 Tag FIFO SHALL be sub-module dma_arb_tag_fifo (push/pop/full/empty/count, synchronous, async reset).

Verification
REQ-028 Req0..3 all valid, len 4096, cmd ready 1 -> grants 0,1,2,3,0 in order, one issue per 2 cycles.
REQ-029 Req1 cmd addr 0x1000 len 128, 2 data beats last on 2nd -> both on m_axis_req_data[1], status_reg[0] 1 then 0.
REQ-030 Issue 16 cmds, no data -> 17th stalled, status_reg[0]=16; one last beat -> 17th granted next cycle.
REQ-031 m_axis_req_data[2].ready 0 while head=2 -> s_axis_dma_read_data.ready 0, no beat lost; release -> beats resume in order.
REQ-032 Len 0 on req3 -> no DMA cmd, status_reg[1][0]=1; data valid with empty FIFO -> ready 0, status_reg[1][1]=1.
REQ-033 rstn low during ISSUE with 5 outstanding -> valid 0 immediately, status_reg[0]=0; with DMA_RD_ARB_STATS_EN grant counters 0.
